// File: rtl/sfp_pkg.sv
// Shared definitions for the sfp_accum post-processing block: activation
// mode encoding and the tile-control FSM state encoding.
package sfp_pkg;

  // Activation selected per tile; the reserved code behaves as bypass.
  typedef enum logic [1:0] {
    ACT_BYPASS = 2'd0,
    ACT_RELU   = 2'd1,
    ACT_LRELU  = 2'd2,
    ACT_RSVD   = 2'd3
  } act_mode_e;

  // Tile control: wait for start, collect psums, hold results until accepted.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/sfp_col.sv
// One output column of sfp_accum: saturating accumulator, pass counter,
// activation and saturation of the result down to PSUM_BW.
// Build option: SFP_ACCUM_LRELU_EN enables the leaky-ReLU shift path;
// without it ACT_LRELU behaves as ReLU and the shift input does not exist.
module sfp_col
  import sfp_pkg::*;
#(
  parameter int PSUM_BW = 16,
  parameter int ACC_BW  = 24,
  parameter int PASS_BW = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear_i,   // start of a new tile
  input  logic               en_i,      // tile is accumulating this cycle
  input  logic               valid_i,
  input  logic [PSUM_BW-1:0] psum_i,
  input  logic [PASS_BW-1:0] pass_i,    // latched target, never zero
  input  act_mode_e          mode_i,
`ifdef SFP_ACCUM_LRELU_EN
  input  logic [2:0]         shift_i,
`endif
  output logic               full_o,    // column complete after this edge
  output logic               sat_o,     // accumulator clamps on this edge
  output logic [PSUM_BW-1:0] act_o      // activated value of next acc state
);

  localparam logic [ACC_BW-1:0]  ACC_MAX  = {1'b0, {(ACC_BW-1){1'b1}}};
  localparam logic [ACC_BW-1:0]  ACC_MIN  = {1'b1, {(ACC_BW-1){1'b0}}};
  localparam logic [PSUM_BW-1:0] PSUM_MAX = {1'b0, {(PSUM_BW-1){1'b1}}};
  localparam logic [PSUM_BW-1:0] PSUM_MIN = {1'b1, {(PSUM_BW-1){1'b0}}};

  logic signed [ACC_BW-1:0]  acc_q, acc_d;
  logic        [PASS_BW-1:0] cnt_q, cnt_d;
  logic signed [ACC_BW:0]    sum;
  logic                      take;
  logic signed [ACC_BW-1:0]  act_v;

  // Next accumulator and pass count: add one psum while the column still
  // owes contributions, clamping on signed overflow.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    acc_d = acc_q;
    cnt_d = cnt_q;
    sat_o = 1'b0;
    take  = en_i && valid_i && (cnt_q < pass_i);
    sum   = (ACC_BW+1)'(acc_q) + (ACC_BW+1)'($signed(psum_i));
    if (take) begin
      cnt_d = cnt_q + 1'b1;
      if (sum[ACC_BW] != sum[ACC_BW-1]) begin
        sat_o = 1'b1;
        acc_d = sum[ACC_BW] ? ACC_MIN : ACC_MAX;
      end else begin
        acc_d = sum[ACC_BW-1:0];
      end
    end
    full_o = (cnt_d == pass_i);
  end

  // Activation of the next accumulator value, then clamp to PSUM_BW.
  always_comb begin
    act_v = acc_d;
    if (acc_d[ACC_BW-1]) begin
      case (mode_i)
        ACT_RELU:  act_v = '0;
`ifdef SFP_ACCUM_LRELU_EN
        ACT_LRELU: act_v = acc_d >>> shift_i;
`else
        ACT_LRELU: act_v = '0;
`endif
        default:   act_v = acc_d;
      endcase
    end
    if ((&act_v[ACC_BW-1:PSUM_BW-1]) || (~|act_v[ACC_BW-1:PSUM_BW-1])) begin
      act_o = act_v[PSUM_BW-1:0];
    end else begin
      act_o = act_v[ACC_BW-1] ? PSUM_MIN : PSUM_MAX;
    end
  end

  // Accumulator state; cleared by reset and by every tile start.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset || clear_i) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sfp_accum.sv
// sfp_accum: per-column partial-sum accumulator with activation and a
// valid/ready result hold. A start pulse latches the tile configuration and
// clears all columns; results are registered once every column has received
// its pass count and held until the downstream handshake.
// Build option: SFP_ACCUM_LRELU_EN enables leaky ReLU for act_mode 2;
// otherwise act_mode 2 behaves as ReLU and shift is ignored.
module sfp_accum
  import sfp_pkg::*;
#(
  parameter int COL     = 8,
  parameter int PSUM_BW = 16,
  parameter int ACC_BW  = 24,
  parameter int PASS_BW = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [PASS_BW-1:0]     pass_num,
  input  logic [1:0]             act_mode,
  input  logic [2:0]             shift,
  input  logic [PSUM_BW*COL-1:0] in_psum,
  input  logic [COL-1:0]         valid_in,
  output logic [PSUM_BW*COL-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   ovf
);

  state_e                   state_q;
  logic [PASS_BW-1:0]       pass_q;
  act_mode_e                mode_q;
  logic [PSUM_BW*COL-1:0]   out_data_q;
  logic                     out_valid_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     ovf_q;

  logic [COL-1:0]           col_full;
  logic [COL-1:0]           col_sat;
  logic [PSUM_BW*COL-1:0]   col_act;
  logic                     col_en;

`ifdef SFP_ACCUM_LRELU_EN
  logic [2:0]               shift_q;
`else
  logic                     unused_shift;
  assign unused_shift = ^shift;
`endif

  // A start in the same cycle pre-empts accumulation: columns clear instead.
  assign col_en = (state_q == S_ACCUM) && !start;

  for (genvar gk = 0; gk < COL; gk++) begin : g_col
    sfp_col #(
      .PSUM_BW (PSUM_BW),
      .ACC_BW  (ACC_BW),
      .PASS_BW (PASS_BW)
    ) u_col (
      .clk     (clk),
      .reset   (reset),
      .clear_i (start),
      .en_i    (col_en),
      .valid_i (valid_in[gk]),
      .psum_i  (in_psum[gk*PSUM_BW +: PSUM_BW]),
      .pass_i  (pass_q),
      .mode_i  (mode_q),
`ifdef SFP_ACCUM_LRELU_EN
      .shift_i (shift_q),
`endif
      .full_o  (col_full[gk]),
      .sat_o   (col_sat[gk]),
      .act_o   (col_act[gk*PSUM_BW +: PSUM_BW])
    );
  end

  // Tile FSM with registered outputs; start overrides every other event,
  // including a handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pass_q      <= '0;
      mode_q      <= ACT_BYPASS;
`ifdef SFP_ACCUM_LRELU_EN
      shift_q     <= '0;
`endif
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        state_q     <= S_ACCUM;
        pass_q      <= (pass_num == '0) ? PASS_BW'(1) : pass_num;
        mode_q      <= act_mode_e'(act_mode);
`ifdef SFP_ACCUM_LRELU_EN
        shift_q     <= shift;
`endif
        out_valid_q <= 1'b0;
        busy_q      <= 1'b1;
        ovf_q       <= 1'b0;
      end else begin
        case (state_q)
          S_ACCUM: begin
            if (|col_sat) ovf_q <= 1'b1;
            if (&col_full) begin
              state_q     <= S_DRAIN;
              out_valid_q <= 1'b1;
              out_data_q  <= col_act;
            end
          end
          S_DRAIN: begin
            if (out_ready) begin
              state_q     <= S_IDLE;
              out_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_sfp_accum.sv
// Self-checking bench for sfp_accum: vector table, hand-written multi-cycle
// sequences and randomized tiles against a plain-arithmetic model.
module tb_sfp_accum;

  localparam int COL = 8;
  localparam int PBW = 16;
  localparam int ABW = 24;

`ifdef SFP_ACCUM_LRELU_EN
  localparam longint LR_EXP  = -16;
  localparam longint LR2_EXP = -8;
`else
  localparam longint LR_EXP  = 0;
  localparam longint LR2_EXP = 0;
`endif

  logic               clk, reset, start, out_ready;
  logic [7:0]         pass_num;
  logic [1:0]         act_mode;
  logic [2:0]         shift;
  logic [PBW*COL-1:0] in_psum, out_data;
  logic [COL-1:0]     valid_in;
  logic               out_valid, busy, done, ovf;

  logic               start_s;
  logic [2*PBW-1:0]   in_psum_s, out_data_s;
  logic [1:0]         valid_in_s;
  logic               out_valid_s, busy_s, done_s, ovf_s;

  int n_checks = 0;
  int n_errors = 0;

  sfp_accum #(.COL(COL), .PSUM_BW(PBW), .ACC_BW(ABW), .PASS_BW(8)) dut (
    .clk(clk), .reset(reset), .start(start), .pass_num(pass_num),
    .act_mode(act_mode), .shift(shift), .in_psum(in_psum), .valid_in(valid_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .ovf(ovf)
  );

  sfp_accum #(.COL(2), .PSUM_BW(16), .ACC_BW(16), .PASS_BW(8)) dut_s (
    .clk(clk), .reset(reset), .start(start_s), .pass_num(pass_num),
    .act_mode(act_mode), .shift(shift), .in_psum(in_psum_s), .valid_in(valid_in_s),
    .out_data(out_data_s), .out_valid(out_valid_s), .out_ready(out_ready),
    .busy(busy_s), .done(done_s), .ovf(ovf_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int     pnum;
    int     mode;
    int     sh;
    longint ps[3];
    longint exp;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint col_of(input logic [PBW*COL-1:0] d, input int k);
    logic signed [PBW-1:0] v;
    v = d[k*PBW +: PBW];
    return longint'(v);
  endfunction

  function automatic longint col_s(input int k);
    logic signed [15:0] v;
    v = out_data_s[k*16 +: 16];
    return longint'(v);
  endfunction

  // Reference: saturating signed add at the given accumulator width.
  function automatic longint sat_add(input longint a, input longint b, input int bw,
                                     output bit sat);
    longint mx, mn, s;
    mx  = (longint'(1) <<< (bw - 1)) - 1;
    mn  = -mx - 1;
    s   = a + b;
    sat = 1'b0;
    if (s > mx) begin s = mx; sat = 1'b1; end
    if (s < mn) begin s = mn; sat = 1'b1; end
    return s;
  endfunction

  // Reference: activation of an accumulated value, clamped to 16 bits.
  function automatic longint act_ref(input longint acc, input int mode, input int sh);
    longint v;
    v = acc;
    if (acc < 0 && (mode == 1 || mode == 2)) begin
`ifdef SFP_ACCUM_LRELU_EN
      if (mode == 2) v = acc >>> sh;
      else           v = 0;
`else
      v = 0;
`endif
    end
    if (v > 32767)  v = 32767;
    if (v < -32768) v = -32768;
    return v;
  endfunction

  task automatic set_col(input int k, input longint v);
    in_psum[k*PBW +: PBW] = PBW'(v);
  endtask

  task automatic begin_tile(input int p, input int m, input int s);
    pass_num = 8'(p);
    act_mode = 2'(m);
    shift    = 3'(s);
    valid_in = '0;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic feed_all(input longint v);
    for (int k = 0; k < COL; k++) set_col(k, v);
    valid_in = '1;
    tick();
    valid_in = '0;
  endtask

  task automatic handshake(input string name);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, "_done"}, done, 1);
    check({name, "_valid_low"}, out_valid, 0);
    tick();
    check({name, "_done_pulse"}, done, 0);
  endtask

  longint acc_m[COL];
  int     cnt_m[COL];
  bit     ovf_m, sat_b, all_done;
  int     tgt, p, m, s, stall;
  logic signed [15:0] r16;

  initial begin
    reset = 1'b1; start = 1'b1; out_ready = 1'b0;
    pass_num = 8'd3; act_mode = 2'd1; shift = 3'd0;
    in_psum = '0; valid_in = '1;
    start_s = 1'b0; in_psum_s = '0; valid_in_s = '0;

    // Reset dominates a concurrent start.
    tick(); tick();
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovf", ovf, 0);
    check("rst_data", longint'(|out_data), 0);
    reset = 1'b0; start = 1'b0; valid_in = '0;
    tick();
    check("rst_idle_busy", busy, 0);

    tbl[0] = '{3, 1, 0, '{5, -2, 4}, 7};
    tbl[1] = '{2, 2, 2, '{-40, -24, 0}, LR_EXP};
    tbl[2] = '{1, 0, 0, '{-300, 0, 0}, -300};
    tbl[3] = '{0, 1, 0, '{-5, 0, 0}, 0};
    tbl[4] = '{2, 3, 0, '{1000, -3000, 0}, -2000};
    tbl[5] = '{2, 0, 0, '{32767, 32767, 0}, 32767};
    tbl[6] = '{3, 0, 0, '{-32768, -32768, -32768}, -32768};
    tbl[7] = '{1, 2, 7, '{-1000, 0, 0}, LR2_EXP};

    for (int i = 0; i < 8; i++) begin
      begin_tile(tbl[i].pnum, tbl[i].mode, tbl[i].sh);
      check($sformatf("tbl%0d_busy", i), busy, 1);
      for (int j = 0; j < ((tbl[i].pnum == 0) ? 1 : tbl[i].pnum); j++) begin
        check($sformatf("tbl%0d_pre_valid%0d", i, j), out_valid, 0);
        feed_all(tbl[i].ps[j]);
      end
      check($sformatf("tbl%0d_valid", i), out_valid, 1);
      for (int k = 0; k < COL; k++)
        check($sformatf("tbl%0d_col%0d", i, k), col_of(out_data, k), tbl[i].exp);
      check($sformatf("tbl%0d_ovf", i), ovf, 0);
      check($sformatf("tbl%0d_done_early", i), done, 0);
      handshake($sformatf("tbl%0d", i));
      check($sformatf("tbl%0d_idle", i), busy, 0);
    end

    // Staggered columns, extra valid on a finished column is ignored.
    begin_tile(2, 0, 0);
    for (int k = 0; k < 4; k++) set_col(k, 10);
    valid_in = 8'h0F; tick();
    check("stg_v1", out_valid, 0);
    for (int k = 0; k < 4; k++) set_col(k, 20);
    tick();
    check("stg_v2", out_valid, 0);
    for (int k = 0; k < 4; k++) set_col(k, 1000);
    for (int k = 4; k < 8; k++) set_col(k, 5);
    valid_in = 8'hFF; tick();
    check("stg_v3", out_valid, 0);
    valid_in = 8'h70; tick();
    check("stg_v4", out_valid, 0);
    valid_in = 8'h80; tick();
    valid_in = '0;
    check("stg_valid", out_valid, 1);
    check("stg_col0", col_of(out_data, 0), 30);
    check("stg_col4", col_of(out_data, 4), 10);
    check("stg_col7", col_of(out_data, 7), 10);
    handshake("stg");

    // Downstream stall: output held and stable, done only after ready.
    begin_tile(1, 0, 0);
    feed_all(-123);
    for (int j = 0; j < 5; j++) begin
      check("stall_valid", out_valid, 1);
      check("stall_col0", col_of(out_data, 0), -123);
      check("stall_col7", col_of(out_data, 7), -123);
      check("stall_done", done, 0);
      tick();
    end
    handshake("stall");

    // Abort mid-accumulation after 2 of 3 passes.
    begin_tile(3, 0, 0);
    feed_all(9);
    feed_all(9);
    begin_tile(3, 0, 0);
    check("abort_busy", busy, 1);
    check("abort_done", done, 0);
    for (int j = 0; j < 3; j++) begin
      check("abort_pre_valid", out_valid, 0);
      feed_all(1);
      check("abort_no_done", done, 0);
    end
    check("abort_valid", out_valid, 1);
    check("abort_col0", col_of(out_data, 0), 3);
    check("abort_col5", col_of(out_data, 5), 3);
    handshake("abort");

    // Start and handshake together in DRAIN: start wins, no done.
    begin_tile(1, 0, 0);
    feed_all(7);
    check("sh_valid", out_valid, 1);
    out_ready = 1'b1; start = 1'b1; pass_num = 8'd1;
    tick();
    start = 1'b0; out_ready = 1'b0;
    check("sh_done", done, 0);
    check("sh_valid_low", out_valid, 0);
    check("sh_busy", busy, 1);
    tick();
    check("sh_done2", done, 0);
    feed_all(2);
    check("sh_col0", col_of(out_data, 0), 2);
    handshake("sh");

    // Reset in the middle of a tile: back to idle, valid_in then ignored.
    begin_tile(2, 0, 0);
    feed_all(4);
    reset = 1'b1; tick(); reset = 1'b0;
    check("rmid_busy", busy, 0);
    check("rmid_valid", out_valid, 0);
    feed_all(4); feed_all(4);
    check("rmid_idle_valid", out_valid, 0);
    check("rmid_idle_busy", busy, 0);

    // Accumulator saturation at ACC_BW=16.
    pass_num = 8'd2; act_mode = 2'd0; shift = 3'd0;
    start_s = 1'b1; tick(); start_s = 1'b0;
    in_psum_s = {16'(-30000), 16'(30000)}; valid_in_s = 2'b11; tick();
    check("sat_ovf_early", ovf_s, 0);
    in_psum_s = {16'(-10000), 16'(10000)}; tick();
    valid_in_s = 2'b00;
    check("sat_valid", out_valid_s, 1);
    check("sat_col0", col_s(0), 32767);
    check("sat_col1", col_s(1), -32768);
    check("sat_ovf", ovf_s, 1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    check("sat_done", done_s, 1);
    check("sat_ovf_sticky", ovf_s, 1);
    start_s = 1'b1; tick(); start_s = 1'b0;
    check("sat_ovf_clear", ovf_s, 0);

    // Randomized tiles against the reference model.
    for (int t = 0; t < 30; t++) begin
      p = $urandom_range(0, 4);
      m = $urandom_range(0, 3);
      s = $urandom_range(0, 7);
      tgt = (p == 0) ? 1 : p;
      ovf_m = 1'b0;
      for (int k = 0; k < COL; k++) begin acc_m[k] = 0; cnt_m[k] = 0; end
      begin_tile(p, m, s);
      all_done = 1'b0;
      for (int cyc = 0; cyc < 200 && !all_done; cyc++) begin
        for (int k = 0; k < COL; k++) begin
          r16 = 16'($urandom);
          set_col(k, longint'(r16));
          valid_in[k] = 1'($urandom);
          if (valid_in[k] && cnt_m[k] < tgt) begin
            acc_m[k] = sat_add(acc_m[k], longint'(r16), ABW, sat_b);
            ovf_m |= sat_b;
            cnt_m[k]++;
          end
        end
        tick();
        all_done = 1'b1;
        for (int k = 0; k < COL; k++) if (cnt_m[k] != tgt) all_done = 1'b0;
        check($sformatf("rnd%0d_valid", t), out_valid, longint'(all_done));
      end
      valid_in = '0;
      if (!all_done) check($sformatf("rnd%0d_timeout", t), 0, 1);
      for (int k = 0; k < COL; k++)
        check($sformatf("rnd%0d_col%0d", t, k), col_of(out_data, k), act_ref(acc_m[k], m, s));
      check($sformatf("rnd%0d_ovf", t), ovf, longint'(ovf_m));
      stall = $urandom_range(0, 3);
      for (int j = 0; j < stall; j++) begin
        tick();
        check($sformatf("rnd%0d_hold", t), out_valid, 1);
        check($sformatf("rnd%0d_hold_col0", t), col_of(out_data, 0), act_ref(acc_m[0], m, s));
      end
      handshake($sformatf("rnd%0d", t));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
